// File: rtl/vga_pattern_gen.sv
// VGA test-pattern generator: RGB565 bands, checker and scrolling bands.
// Two-stage pipeline; mode and scroll change only at frame start.
module vga_pattern_gen #(
  parameter int ADDR_W      = 12,
  parameter int H_ACTIVE    = 800,
  parameter int V_ACTIVE    = 600,
  parameter int BAND_SHIFT  = 7,
  parameter int SCROLL_STEP = 1,
  parameter int R_W         = 5,
  parameter int G_W         = 6,
  parameter int B_W         = 5
) (
  input  logic              vga_clk,
  input  logic              rst_n,
  input  logic              Ready_Sig,
  input  logic [ADDR_W-1:0] Column_Addr_Sig,
  input  logic [ADDR_W-1:0] Row_Addr_Sig,
  input  logic [1:0]        Mode_Sig,
  input  logic              Scroll_En,
  output logic [R_W-1:0]    Red_Sig,
  output logic [G_W-1:0]    Green_Sig,
  output logic [B_W-1:0]    Blue_Sig,
  output logic              Pixel_Valid,
  output logic              Frame_Start
);

  localparam logic [ADDR_W-1:0] H_LIM =
    ADDR_W'(H_ACTIVE);
  localparam logic [ADDR_W-1:0] V_LIM =
    ADDR_W'(V_ACTIVE);
  localparam logic [ADDR_W:0] V_WRAP =
    (ADDR_W+1)'(V_ACTIVE);
  localparam logic [ADDR_W:0] STEP =
    (ADDR_W+1)'(SCROLL_STEP);

  localparam logic [1:0] M_HB = 2'd0;
  localparam logic [1:0] M_VB = 2'd1;
  localparam logic [1:0] M_CK = 2'd2;
  localparam logic [1:0] M_SC = 2'd3;

  typedef struct packed {
    logic       v;
    logic       rdy;
    logic       fs;
    logic [1:0] mode;
    logic [2:0] hb;
    logic [2:0] vb;
    logic       ck;
  } st1_t;

  logic              fs;
  logic [1:0]        mode_q;
  logic [ADDR_W-1:0] scroll_q;
  logic [ADDR_W:0]   scr_sum;
  logic [ADDR_W-1:0] scr_nxt;
  logic [ADDR_W:0]   row_ext;
  logic [ADDR_W:0]   row_sum;
  logic [ADDR_W:0]   erow;
  logic [2:0]        hb_c;
  logic [2:0]        vb_c;
  logic              v_c;
  st1_t              s1;
  logic [2:0]        pidx;
  logic [2:0]        rgb_on;

  assign fs = Ready_Sig
           && (Column_Addr_Sig == '0)
           && (Row_Addr_Sig == '0);

  // Next scroll offset, wrapped into 0..V_ACTIVE-1
  always_comb begin
    scr_sum = {1'b0, scroll_q} + STEP;
    scr_nxt = ADDR_W'(scroll_q);
    if (scr_sum >= V_WRAP)
      scr_nxt = ADDR_W'(scr_sum - V_WRAP);
    else
      scr_nxt = ADDR_W'(scr_sum);
  end

  // Frame-start latch of mode and scroll offset
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q   <= M_HB;
      scroll_q <= '0;
    end else if (fs) begin
      mode_q <= Mode_Sig;
      if (Mode_Sig != M_SC)
        scroll_q <= '0;
      else if (Scroll_En)
        scroll_q <= scr_nxt;
    end
  end

  // Effective row and band indices for stage 1
  always_comb begin
    row_ext = {1'b0, Row_Addr_Sig};
    row_sum = row_ext + {1'b0, scroll_q};
    erow    = row_ext;
    if (mode_q == M_SC) begin
      if (row_sum >= V_WRAP)
        erow = row_sum - V_WRAP;
      else
        erow = row_sum;
    end
    hb_c = 3'(erow >> BAND_SHIFT);
    vb_c = 3'(Column_Addr_Sig >> BAND_SHIFT);
    v_c  = Ready_Sig
        && (Column_Addr_Sig < H_LIM)
        && (Row_Addr_Sig < V_LIM);
  end

  // Stage 1: register band indices with the mode in force
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
    end else begin
      s1.v    <= v_c;
      s1.rdy  <= Ready_Sig;
      s1.fs   <= fs;
      s1.mode <= mode_q;
      s1.hb   <= hb_c;
      s1.vb   <= vb_c;
      s1.ck   <= hb_c[0] ^ vb_c[0];
    end
  end

  // Palette index from the stage-1 mode
  always_comb begin
    pidx = s1.hb;
    unique case (1'b1)
      (s1.mode == M_VB): pidx = s1.vb;
      (s1.mode == M_CK): pidx = s1.ck ? 3'd7 : 3'd0;
      default:           pidx = s1.hb;
    endcase
  end

  // Palette: which channels are at full scale
  always_comb begin
    rgb_on = 3'b000;
    unique case (pidx)
      3'd0:    rgb_on = 3'b111;
      3'd1:    rgb_on = 3'b100;
      3'd2:    rgb_on = 3'b010;
      3'd3:    rgb_on = 3'b001;
      3'd4:    rgb_on = 3'b110;
      3'd5:    rgb_on = 3'b011;
      3'd6:    rgb_on = 3'b101;
      default: rgb_on = 3'b000;
    endcase
  end

  // Stage 2: registered colour and timing outputs
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      Red_Sig     <= '0;
      Green_Sig   <= '0;
      Blue_Sig    <= '0;
      Pixel_Valid <= 1'b0;
      Frame_Start <= 1'b0;
    end else begin
      Red_Sig     <= {R_W{s1.v & rgb_on[2]}};
      Green_Sig   <= {G_W{s1.v & rgb_on[1]}};
      Blue_Sig    <= {B_W{s1.v & rgb_on[0]}};
      Pixel_Valid <= s1.rdy;
      Frame_Start <= s1.fs;
    end
  end

endmodule
